// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_if
// Description : Shared-bus request/grant and strobe bundle seen by the arbiter.
//               The arbiter connects through the slave modport; requesters and
//               bus observers connect through the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
    parameter int MASTERS = 2
);
    logic [MASTERS-1:0] bus_req;
    logic [MASTERS-1:0] bus_grant;
    logic               rd_bus;
    logic               wr_bus;
    logic               fc_bus;
    logic               watchdog;

    modport slave (
        input  bus_req,
        input  rd_bus,
        input  wr_bus,
        input  fc_bus,
        output bus_grant,
        output watchdog
    );

    modport master (
        output bus_req,
        output rd_bus,
        output wr_bus,
        output fc_bus,
        input  bus_grant,
        input  watchdog
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Central shared-bus arbiter with one-cycle dead handover and a
//               transfer watchdog. Master 0 is the default owner.
//               BUS_ARBITER_ROUND_ROBIN_EN selects round-robin winner choice
//               among masters 1..MASTERS-1 (default: highest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int MASTERS = 2,
    parameter int TIMEOUT = 256,
    parameter int WD_W    = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    bus_arbiter_if.slave     bus
);

    localparam int OW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    localparam logic [0:0] ST_GRANTED  = 1'b0;
    localparam logic [0:0] ST_HANDOVER = 1'b1;

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [0:0]      state_q,    state_d;
    logic [OW-1:0]   owner_q,    owner_d;
    logic [WD_W-1:0] wd_cnt_q,   wd_cnt_d;
    logic            watchdog_q, watchdog_d;

    logic            bus_active;
    logic            any_req;
    logic [OW-1:0]   winner;
    logic [MASTERS-1:0] grant;

    assign bus_active = bus.rd_bus ^ bus.wr_bus;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    logic [OW-1:0] last_winner_q, last_winner_d;

    // Search order: last_winner+1 .. MASTERS-1, then wrap to 1; index 0 never competes.
    always_comb begin
        int cand;
        winner  = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int k = 0; k < MASTERS - 1; k++) begin
            cand = int'(last_winner_q) + k + 1;
            if (cand > MASTERS - 1) begin
                cand = cand - (MASTERS - 1);
            end
            if (!any_req && bus.bus_req[cand]) begin
                winner  = OW'(cand);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        last_winner_d = last_winner_q;
        if (state_q == ST_HANDOVER && owner_q != '0) begin
            last_winner_d = owner_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner_q <= '0;
        end else begin
            last_winner_q <= last_winner_d;
        end
    end
`else
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int i = 1; i < MASTERS; i++) begin
            if (bus.bus_req[i]) begin
                winner  = OW'(i);
                any_req = 1'b1;
            end
        end
    end
`endif

    // During HANDOVER owner_q already holds the incoming master; the grant is simply masked.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_GRANTED: begin
                if (!bus_active) begin
                    if (owner_q == '0) begin
                        if (any_req) begin
                            owner_d = winner;
                            state_d = ST_HANDOVER;
                        end
                    end else if (!bus.bus_req[owner_q]) begin
                        owner_d = winner;
                        state_d = ST_HANDOVER;
                    end
                end
            end
            ST_HANDOVER: begin
                state_d = ST_GRANTED;
            end
            default: begin
                state_d = ST_GRANTED;
                owner_d = '0;
            end
        endcase
    end

    // fc_bus takes precedence over the terminal count, so no pulse when both coincide.
    always_comb begin
        wd_cnt_d   = wd_cnt_q + WD_W'(1);
        watchdog_d = 1'b0;
        if (state_q == ST_HANDOVER || !bus_active || bus.fc_bus) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q == WD_LAST) begin
            wd_cnt_d   = '0;
            watchdog_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_GRANTED;
            owner_q    <= '0;
            wd_cnt_q   <= '0;
            watchdog_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wd_cnt_q   <= wd_cnt_d;
            watchdog_q <= watchdog_d;
        end
    end

    always_comb begin
        grant = '0;
        if (state_q == ST_GRANTED) begin
            grant[owner_q] = 1'b1;
        end
    end

    assign bus.bus_grant = grant;
    assign bus.watchdog  = watchdog_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Scoreboard bench for bus_arbiter (MASTERS=3, TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bus_arbiter_if #(.MASTERS(3)) bif ();

    bus_arbiter #(
        .MASTERS (3),
        .TIMEOUT (8),
        .WD_W    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] grant;
        logic       wd;
    } exp_t;

    exp_t  sb[$];
    int    tests_run    = 0;
    int    tests_failed = 0;
    string phase        = "reset";
    int    cyc_no       = 0;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    localparam logic [2:0] ALT_SECOND = 3'b010;
`else
    localparam logic [2:0] ALT_SECOND = 3'b100;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive inputs before the edge, queue the outputs expected after it.
    task automatic cyc(input logic [2:0] req, input logic rd, input logic wr, input logic fc,
                       input logic [2:0] eg, input logic ew);
        exp_t e;
        @(negedge clk);
        #1;
        bif.bus_req = req;
        bif.rd_bus  = rd;
        bif.wr_bus  = wr;
        bif.fc_bus  = fc;
        e.grant = eg;
        e.wd    = ew;
        sb.push_back(e);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            cyc_no++;
            check_eq($sformatf("%s/grant@%0d", phase, cyc_no), {29'd0, bif.bus_grant}, {29'd0, e.grant});
            check_eq($sformatf("%s/watchdog@%0d", phase, cyc_no), {31'd0, bif.watchdog}, {31'd0, e.wd});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bif.bus_req = '0;
        bif.rd_bus  = 1'b0;
        bif.wr_bus  = 1'b0;
        bif.fc_bus  = 1'b0;
        #2;
        check_eq("reset/grant", {29'd0, bif.bus_grant}, 32'h1);
        check_eq("reset/watchdog", {31'd0, bif.watchdog}, 32'h0);
        #10;
        rst = 1'b0;

        phase = "handover";
        cyc(3'b000, 0, 0, 0, 3'b001, 0);
        cyc(3'b010, 0, 0, 0, 3'b000, 0);
        cyc(3'b010, 0, 0, 0, 3'b010, 0);
        cyc(3'b010, 0, 0, 0, 3'b010, 0);
        cyc(3'b000, 0, 0, 0, 3'b000, 0);
        cyc(3'b000, 0, 0, 0, 3'b001, 0);

        phase = "busy_hold";
        repeat (5) cyc(3'b010, 1, 0, 0, 3'b001, 0);
        cyc(3'b010, 0, 0, 0, 3'b000, 0);
        cyc(3'b010, 0, 0, 0, 3'b010, 0);
        cyc(3'b000, 0, 0, 0, 3'b000, 0);
        cyc(3'b000, 0, 0, 0, 3'b001, 0);

        phase = "both_high_idle";
        repeat (10) cyc(3'b000, 1, 1, 0, 3'b001, 0);
        cyc(3'b010, 1, 1, 0, 3'b000, 0);
        cyc(3'b010, 1, 1, 0, 3'b010, 0);
        cyc(3'b000, 0, 0, 0, 3'b000, 0);
        cyc(3'b000, 0, 0, 0, 3'b001, 0);

        phase = "wd_period";
        for (int i = 1; i <= 16; i++) begin
            cyc(3'b000, 0, 1, 0, 3'b001, (i == 8 || i == 16));
        end
        cyc(3'b000, 0, 0, 0, 3'b001, 0);

        phase = "wd_fc_wins";
        repeat (7) cyc(3'b000, 0, 1, 0, 3'b001, 0);
        cyc(3'b000, 0, 1, 1, 3'b001, 0);
        repeat (7) cyc(3'b000, 0, 1, 0, 3'b001, 0);
        cyc(3'b000, 0, 0, 0, 3'b001, 0);

        phase = "wd_100_xfers";
        for (int t = 0; t < 100; t++) begin
            logic rd;
            rd = 1'($urandom_range(0, 1));
            cyc(3'b000, rd, !rd, 0, 3'b001, 0);
            cyc(3'b000, rd, !rd, 0, 3'b001, 0);
            cyc(3'b000, rd, !rd, 1, 3'b001, 0);
            cyc(3'b000, 0, 0, 0, 3'b001, 0);
        end

        phase = "priority";
        cyc(3'b110, 0, 0, 0, 3'b000, 0);
        cyc(3'b110, 0, 0, 0, 3'b100, 0);
        cyc(3'b110, 0, 0, 0, 3'b100, 0);
        cyc(3'b010, 0, 0, 0, 3'b000, 0);
        cyc(3'b010, 0, 0, 0, 3'b010, 0);
        cyc(3'b000, 0, 0, 0, 3'b000, 0);
        cyc(3'b000, 0, 0, 0, 3'b001, 0);

        phase = "alternate";
        for (int r = 0; r < 2; r++) begin
            cyc(3'b110, 0, 0, 0, 3'b000, 0);
            cyc(3'b110, 0, 0, 0, (r == 0) ? 3'b100 : ALT_SECOND, 0);
            cyc(3'b000, 0, 0, 0, 3'b000, 0);
            cyc(3'b000, 0, 0, 0, 3'b001, 0);
        end

        phase = "no_preempt";
        cyc(3'b010, 0, 0, 0, 3'b000, 0);
        cyc(3'b010, 0, 0, 0, 3'b010, 0);
        cyc(3'b110, 0, 0, 0, 3'b010, 0);
        cyc(3'b110, 0, 0, 0, 3'b010, 0);
        cyc(3'b100, 0, 0, 0, 3'b000, 0);
        cyc(3'b100, 0, 0, 0, 3'b100, 0);
        cyc(3'b000, 0, 0, 0, 3'b000, 0);
        cyc(3'b000, 0, 0, 0, 3'b001, 0);

        phase = "reset_mid_xfer";
        cyc(3'b010, 0, 0, 0, 3'b000, 0);
        cyc(3'b010, 0, 0, 0, 3'b010, 0);
        repeat (5) cyc(3'b010, 0, 1, 0, 3'b010, 0);
        drain();
        rst = 1'b1;
        #1;
        check_eq("rst_async/grant", {29'd0, bif.bus_grant}, 32'h1);
        check_eq("rst_async/watchdog", {31'd0, bif.watchdog}, 32'h0);
        bif.bus_req = 3'b000;
        @(posedge clk);
        #1;
        check_eq("rst_held/grant", {29'd0, bif.bus_grant}, 32'h1);
        check_eq("rst_held/watchdog", {31'd0, bif.watchdog}, 32'h0);
        #2;
        rst = 1'b0;

        phase = "wd_after_reset";
        for (int i = 1; i <= 8; i++) begin
            cyc(3'b000, 0, 1, 0, 3'b001, (i == 8));
        end
        drain();
        rst = 1'b1;
        #1;
        check_eq("rst_cancel/watchdog", {31'd0, bif.watchdog}, 32'h0);
        check_eq("rst_cancel/grant", {29'd0, bif.bus_grant}, 32'h1);
        bif.wr_bus = 1'b0;
        #1;
        rst = 1'b0;

        phase = "post_reset";
        cyc(3'b000, 0, 0, 0, 3'b001, 0);
        cyc(3'b000, 0, 0, 0, 3'b001, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
